// File: rtl/array_allocator_if.sv
// Request/response bus between a requester and the array handle allocator.
// The requester drives the request fields and rsp_ready. The allocator
// drives req_ready, the response fields and the allocs/in_use counters.
interface array_allocator_if #(
  parameter int MemoryElementWidth = 12
);
  logic                          req_valid;
  logic                          req_ready;
  logic                          req_op;
  logic [MemoryElementWidth-1:0] req_handle;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [MemoryElementWidth-1:0] rsp_handle;
  logic                          rsp_error;
  logic [MemoryElementWidth-1:0] allocs;
  logic [MemoryElementWidth-1:0] in_use;

  modport master (
    output req_valid, req_op, req_handle, rsp_ready,
    input  req_ready, rsp_valid, rsp_handle, rsp_error, allocs, in_use
  );

  modport slave (
    input  req_valid, req_op, req_handle, rsp_ready,
    output req_ready, rsp_valid, rsp_handle, rsp_error, allocs, in_use
  );
endinterface

// File: rtl/array_allocator.sv
// Array handle allocator.
// Handles are issued fresh (0, 1, 2, ...) until NArrays have been handed out.
// Freed handles go onto a LIFO stack and are reused before any fresh handle.
// A live bitmap rejects double frees and frees of handles never issued.
// Each request runs IDLE -> EXEC -> RESPOND, so one operation is in flight.
// The width parameter of the bus interface must equal MemoryElementWidth.
module array_allocator #(
  parameter int MemoryElementWidth = 12,
  parameter int NArrays            = 8
) (
  input  logic              clock,
  input  logic              reset,
  array_allocator_if.slave  bus
);

  localparam int W  = MemoryElementWidth;
  // Counters need one spare bit so that they can hold NArrays == 2**W.
  localparam int CW = W + 1;
  localparam int IW = (NArrays > 1) ? $clog2(NArrays) : 1;
  localparam logic [CW-1:0] NARR = CW'(NArrays);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   accept;

  // Request captured at acceptance
  logic         op_p0;
  logic [W-1:0] handle_p0;

  // Allocator bookkeeping
  logic [CW-1:0]    freed_top_q;
  logic [CW-1:0]    allocs_q;
  logic [CW-1:0]    in_use_q;
  logic [NArrays-1:0] live_q;
  logic [W-1:0]     stack_q [NArrays];

  // Registered response
  logic [W-1:0] rsp_handle_p1;
  logic         rsp_error_p1;

  // Decision made in EXEC
  logic         pop_hit;
  logic         fresh_hit;
  logic         free_ok;
  logic [IW-1:0] push_idx;
  logic [IW-1:0] top_idx;
  logic [IW-1:0] handle_idx;
  logic [W-1:0]  pop_handle;

  // freed_top never exceeds NArrays, and the stack is only read when
  // freed_top > 0, so the low bits minus one address the top entry.
  assign push_idx   = freed_top_q[IW-1:0];
  assign top_idx    = push_idx - IW'(1);
  assign handle_idx = handle_p0[IW-1:0];
  assign pop_handle = stack_q[top_idx];

  // Next-state and handshake outputs
  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    accept        = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = !reset;
        accept        = bus.req_valid && !reset;
        if (accept) state_d = EXEC;
      end
      EXEC: begin
        state_d = RESPOND;
      end
      RESPOND: begin
        bus.rsp_valid = !reset;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Classify the captured request. Only one of the three hits can be set.
  always_comb begin
    pop_hit   = 1'b0;
    fresh_hit = 1'b0;
    free_ok   = 1'b0;
    if (state_q == EXEC) begin
      if (!op_p0) begin
        if (freed_top_q != '0)   pop_hit   = 1'b1;
        else if (allocs_q < NARR) fresh_hit = 1'b1;
      end else if (({1'b0, handle_p0} < allocs_q) && live_q[handle_idx]) begin
        free_ok = 1'b1;
      end
    end
  end

  // ---- stage p0: capture request on acceptance ----
  // Request operands are pure data and need no reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      op_p0     <= bus.req_op;
      handle_p0 <= bus.req_handle;
    end
  end

  // ---- stage p1: execute (counters, live bitmap, stack, response) ----
  // Counter and live bitmap updates for the operation in EXEC.
  always_ff @(posedge clock) begin
    if (reset) begin
      freed_top_q <= '0;
      allocs_q    <= '0;
      in_use_q    <= '0;
      live_q      <= '0;
    end else begin
      if (pop_hit) begin
        freed_top_q                 <= freed_top_q - CW'(1);
        live_q[pop_handle[IW-1:0]]  <= 1'b1;
        in_use_q                    <= in_use_q + CW'(1);
      end
      if (fresh_hit) begin
        allocs_q                    <= allocs_q + CW'(1);
        live_q[allocs_q[IW-1:0]]    <= 1'b1;
        in_use_q                    <= in_use_q + CW'(1);
      end
      if (free_ok) begin
        freed_top_q                 <= freed_top_q + CW'(1);
        live_q[handle_idx]          <= 1'b0;
        in_use_q                    <= in_use_q - CW'(1);
      end
    end
  end

  // Freed-handle stack; entries above freed_top are dead, so no reset.
  always_ff @(posedge clock) begin
    if (free_ok) stack_q[push_idx] <= handle_p0;
  end

  // Response is formed in EXEC and held through RESPOND.
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_handle_p1 <= '0;
      rsp_error_p1  <= 1'b0;
    end else if (state_q == EXEC) begin
      if (pop_hit)        rsp_handle_p1 <= pop_handle;
      else if (fresh_hit) rsp_handle_p1 <= allocs_q[W-1:0];
      else if (op_p0)     rsp_handle_p1 <= handle_p0;
      else                rsp_handle_p1 <= '0;
      rsp_error_p1 <= !(pop_hit || fresh_hit || free_ok);
    end
  end

  assign bus.rsp_handle = rsp_handle_p1;
  assign bus.rsp_error  = rsp_error_p1;
  assign bus.allocs     = allocs_q[W-1:0];
  assign bus.in_use     = in_use_q[W-1:0];

endmodule

// File: doc/array_allocator.md
ARRAY_ALLOCATOR -- requirements
Module: array_allocator

Interface
REQ-001 SHALL have parameter MemoryElementWidth, default 12, width of handles and counters.
REQ-002 SHALL have parameter NArrays, default 8, maximum number of array handles, 1..2**MemoryElementWidth.
REQ-003 SHALL have port clock  input  1  driving clock; all state changes on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  allocator can accept a request.
REQ-007 SHALL have port req_op  input  1  0 = allocate, 1 = free.
REQ-008 SHALL have port req_handle  input  MemoryElementWidth  handle to free; ignored for allocate.
REQ-009 SHALL have port rsp_valid  output  1  response present.
REQ-010 SHALL have port rsp_ready  input  1  requester accepts response.
REQ-011 SHALL have port rsp_handle  output  MemoryElementWidth  allocated handle, or echoed freed handle.
REQ-012 SHALL have port rsp_error  output  1  request rejected.
REQ-013 SHALL have port allocs  output  MemoryElementWidth  count of distinct handles ever issued since reset (high-water mark).
REQ-014 SHALL have port in_use  output  MemoryElementWidth  count of handles currently allocated.

Function
REQ-015 SHALL implement three states: IDLE, EXEC, RESPOND.
REQ-016 SHALL assert req_ready only in IDLE; request accepted on req_valid && req_ready; req_op and req_handle captured that cycle; IDLE -> EXEC.
REQ-017 SHALL in EXEC perform the operation in exactly one cycle, then EXEC -> RESPOND; rsp_valid rises the cycle after EXEC (2 cycles after acceptance).
REQ-018 SHALL hold rsp_valid, rsp_handle, rsp_error stable in RESPOND until rsp_valid && rsp_ready; then RESPOND -> IDLE; next request accepted no earlier than the following cycle.
REQ-019 SHALL keep a freed-handle LIFO stack of depth NArrays with top pointer freedTop, plus a per-handle live bitmap.
REQ-020 Allocate, freedTop > 0: pop; freedTop decrements; handle = stack[freedTop-1]; allocs unchanged.
REQ-021 Allocate, freedTop == 0 and allocs < NArrays: handle = allocs; allocs increments.
REQ-022 Allocate, freedTop == 0 and allocs == NArrays: rsp_error = 1, rsp_handle = 0, no state change.
REQ-023 Successful allocate SHALL set the handle's live bit and increment in_use.
REQ-024 Free, handle < allocs and live bit set: push handle, freedTop increments, clear live bit, decrement in_use; rsp_handle = handle, rsp_error = 0.
REQ-025 Free of handle >= allocs (never issued) or live bit clear (double free): rsp_error = 1, rsp_handle = handle, no state change.
REQ-026 Stack SHALL never overflow: pushes only occur for live handles, so freedTop <= allocs <= NArrays.
REQ-027 req_valid while not in IDLE SHALL be ignored (not captured) since req_ready is low.

Reset
REQ-028 On reset: state = IDLE, freedTop = 0, allocs = 0, in_use = 0, all live bits clear.
REQ-029 On reset: req_ready = 0 during the reset cycle, 1 the cycle after; rsp_valid = 0, rsp_handle = 0, rsp_error = 0.
REQ-030 Reset in EXEC or RESPOND SHALL abandon the in-flight operation; no response delivered.
REQ-031 Stack contents need not be cleared; they are unreachable after reset.

Verification
REQ-032 Alloc, free, alloc, free, alloc, free -> alloc responses handle 0, 0, 0; all rsp_error = 0; final allocs = 1, in_use = 0.
REQ-033 Alloc x3 -> 0,1,2; free 1, free 2; alloc x2 -> 2 then 1 (LIFO); allocs = 3, in_use = 3.
REQ-034 NArrays = 8: alloc x8 -> 0..7; 9th alloc -> rsp_error = 1, rsp_handle = 0; free 5 then alloc -> 5, no error.
REQ-035 Alloc -> 0; free 0 -> ok; free 0 again -> rsp_error = 1; free 3 (never issued) -> rsp_error = 1, rsp_handle = 3; in_use = 0.
REQ-036 Hold rsp_ready low 5 cycles after rsp_valid -> response stable, req_ready low throughout; release -> one handshake, req_ready high next cycle.
REQ-037 Assert reset while in RESPOND -> rsp_valid = 0 next cycle; subsequent alloc -> handle 0, allocs = 1.
